// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-logic core: flap detection, bird physics,
// pipe/ground collision, BCD score and session best score.
module flappy_game_ctrl #(
    parameter int          SCREEN_H    = 480,
    parameter int          BIRD_Y0     = 232,
    parameter int          BIRD_H      = 16,
    parameter int          GRAVITY     = 1,
    parameter int          FLAP_VEL    = -8,
    parameter int          VMAX        = 8,
    parameter logic [4:0]  FLAP_KEY    = 5'h10,
    parameter int          DEAD_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_tick,
    input  logic        key_ready,
    input  logic [4:0]  key_code,
    input  logic        pipe_at_bird,
    input  logic [9:0]  gap_top,
    input  logic [9:0]  gap_bot,
    input  logic        pipe_pass,
    output logic [1:0]  state,
    output logic [9:0]  bird_y,
    output logic [7:0]  bird_vel,
    output logic [15:0] score_bcd,
    output logic [15:0] best_bcd
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_FLY  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(DEAD_FRAMES + 1);

    localparam logic [9:0]         Y0    = 10'(BIRD_Y0);
    localparam logic [9:0]         Y_GND = 10'(SCREEN_H - BIRD_H);
    localparam logic signed [11:0] SH12  = 12'(SCREEN_H);
    localparam logic signed [11:0] BH12  = 12'(BIRD_H);
    localparam logic signed [8:0]  GR9   = 9'(GRAVITY);
    localparam logic signed [8:0]  VMAX9 = 9'(VMAX);
    localparam logic signed [7:0]  VMAX8 = 8'(VMAX);
    localparam logic signed [7:0]  FV8   = 8'(FLAP_VEL);
    localparam logic [CNT_W-1:0]   DF    = CNT_W'(DEAD_FRAMES);

    state_t            st_q, st_n;
    logic              key_q;
    logic              pend_q, pend_n;
    logic [9:0]        y_q, y_n;
    logic signed [7:0] v_q, v_n;
    logic [15:0]       score_q, score_n;
    logic [15:0]       best_q, best_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    logic              flap_edge;
    logic [15:0]       score_inc;
    logic [15:0]       score_fly;
    logic signed [8:0] v_add;
    logic signed [7:0] v_fly;
    logic signed [7:0] v_c;
    logic signed [11:0] y_raw;
    logic signed [11:0] y_c;
    logic              ground;
    logic              hit;

    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        if (s == 16'h9999) begin
            return s;
        end
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign flap_edge = key_ready && !key_q && (key_code == FLAP_KEY);
    assign score_inc = bcd_inc(score_q);
    assign score_fly = pipe_pass ? score_inc : score_q;

    // Frame physics; y is carried in 12-bit signed so ceiling underflow is visible
    assign v_add  = {v_q[7], v_q} + GR9;
    assign v_fly  = pend_q ? FV8 : ((v_add > VMAX9) ? VMAX8 : v_add[7:0]);
    assign y_raw  = $signed({2'b00, y_q}) + $signed({{4{v_fly[7]}}, v_fly});
    assign y_c    = y_raw[11] ? 12'sd0 : y_raw;
    assign v_c    = y_raw[11] ? 8'sd0 : v_fly;
    assign ground = (y_c + BH12) >= SH12;
    assign hit    = pipe_at_bird &&
                    ((y_c < $signed({2'b00, gap_top})) ||
                     ((y_c + BH12) > $signed({2'b00, gap_bot})));

    always_comb begin
        st_n    = st_q;
        pend_n  = pend_q;
        y_n     = y_q;
        v_n     = v_q;
        score_n = score_q;
        best_n  = best_q;
        cnt_n   = cnt_q;
        unique case (st_q)
            S_WAIT: begin
                y_n = Y0;
                v_n = 8'sd0;
                if (flap_edge) begin
                    st_n   = S_FLY;
                    pend_n = 1'b1;
                end
            end
            S_FLY: begin
                score_n = score_fly;
                pend_n  = pend_q | flap_edge;
                if (frame_tick) begin
                    if (pend_q) begin
                        pend_n = flap_edge;
                    end
                    y_n = y_c[9:0];
                    v_n = v_c;
                    if (ground || hit) begin
                        if (ground) begin
                            y_n = Y_GND;
                        end
                        st_n   = S_DEAD;
                        pend_n = 1'b0;
                        cnt_n  = '0;
                        if (score_fly > best_q) begin
                            best_n = score_fly;
                        end
                    end
                end
            end
            S_DEAD: begin
                pend_n = 1'b0;
                if (frame_tick && cnt_q < DF) begin
                    cnt_n = cnt_q + 1'b1;
                end
                if (flap_edge && cnt_q == DF) begin
                    st_n    = S_WAIT;
                    score_n = 16'h0000;
                    y_n     = Y0;
                    v_n     = 8'sd0;
                end
            end
            default: begin
                st_n   = S_WAIT;
                pend_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= S_WAIT;
            key_q   <= 1'b0;
            pend_q  <= 1'b0;
            y_q     <= Y0;
            v_q     <= 8'sd0;
            score_q <= 16'h0000;
            best_q  <= 16'h0000;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_n;
            key_q   <= key_ready;
            pend_q  <= pend_n;
            y_q     <= y_n;
            v_q     <= v_n;
            score_q <= score_n;
            best_q  <= best_n;
            cnt_q   <= cnt_n;
        end
    end

    assign state     = st_q;
    assign bird_y    = y_q;
    assign bird_vel  = v_q;
    assign score_bcd = score_q;
    assign best_bcd  = best_q;

endmodule
